// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared LED code constants, phase enum and decode helpers
//
// Purpose: common definitions for the traffic-light phase monitor.
//   LED_* : active-low LED codes as seen on the bus
//   phase_e : tracked phase; PH_NONE doubles as the unlocked (SYNC) state
//   phase_succ : next phase in the red -> green -> blue -> red order
//   led_to_phase : decode a legal colour code, PH_NONE for off/illegal
//   led_is_illegal : true for codes that are neither a colour nor off
package traffic_pkg;

  localparam logic [2:0] LED_RED   = 3'b101;
  localparam logic [2:0] LED_GREEN = 3'b110;
  localparam logic [2:0] LED_BLUE  = 3'b011;
  localparam logic [2:0] LED_OFF   = 3'b111;

  typedef enum logic [1:0] {
    PH_NONE  = 2'd0,
    PH_RED   = 2'd1,
    PH_GREEN = 2'd2,
    PH_BLUE  = 2'd3
  } phase_e;

  function automatic phase_e phase_succ(phase_e p);
    case (p)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_BLUE;
      PH_BLUE:  return PH_RED;
      default:  return PH_NONE;
    endcase
  endfunction

  function automatic phase_e led_to_phase(logic [2:0] code);
    case (code)
      LED_RED:   return PH_RED;
      LED_GREEN: return PH_GREEN;
      LED_BLUE:  return PH_BLUE;
      default:   return PH_NONE;
    endcase
  endfunction

  function automatic logic led_is_illegal(logic [2:0] code);
    return !(code inside {LED_RED, LED_GREEN, LED_BLUE, LED_OFF});
  endfunction

endpackage

// File: rtl/traffic_phase_monitor_if.sv
// rtl/traffic_phase_monitor_if.sv - LED bus observation and monitor result signals
//
// Purpose: bundles the observed LED code and all monitor results.
//   led_in[2:0]      observed active-low LED code
//   phase[1:0]       tracked phase (0 none, 1 red, 2 green, 3 blue)
//   phase_valid      monitor locked to the sequence
//   err_code         pulse: illegal code
//   err_order        pulse: legal code out of order
//   err_len          pulse: phase length wrong
//   cycle_done       pulse: full correct cycle
//   cycle_count[7:0] saturating count of correct cycles
//   err_status[2:0]  sticky {len, order, code}, only with MON_STICKY_ERR_EN
// Modports: master drives led_in (bus side), slave is the monitor.
interface traffic_phase_monitor_if;
  logic [2:0] led_in;
  logic [1:0] phase;
  logic       phase_valid;
  logic       err_code;
  logic       err_order;
  logic       err_len;
  logic       cycle_done;
  logic [7:0] cycle_count;
`ifdef MON_STICKY_ERR_EN
  logic [2:0] err_status;
`endif

  modport slave (
    input  led_in,
    output phase, phase_valid, err_code, err_order, err_len, cycle_done, cycle_count
`ifdef MON_STICKY_ERR_EN
    , output err_status
`endif
  );

  modport master (
    output led_in,
    input  phase, phase_valid, err_code, err_order, err_len, cycle_done, cycle_count
`ifdef MON_STICKY_ERR_EN
    , input err_status
`endif
  );
endinterface

// File: rtl/traffic_run_counter.sv
// rtl/traffic_run_counter.sv - saturating run-length counter with restart
//
// Purpose: counts how many cycles the sampled LED code has been held.
//   clk        system clock
//   rst        asynchronous active-low reset (count returns to 1)
//   restart_i  code changed this edge: count becomes 1
//   run_len_o  current run length, saturates at 2^CNT_W-1
module traffic_run_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  output logic [CNT_W-1:0] run_len_o
);

  logic [CNT_W-1:0] run_len_q, run_len_d;

  always_comb begin
    run_len_d = run_len_q;
    if (restart_i) begin
      run_len_d = CNT_W'(1);
    end else if (run_len_q != {CNT_W{1'b1}}) begin
      run_len_d = run_len_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_len_q <= CNT_W'(1);
    end else begin
      run_len_q <= run_len_d;
    end
  end

  assign run_len_o = run_len_q;

endmodule

// File: rtl/traffic_phase_monitor.sv
// rtl/traffic_phase_monitor.sv - passive checker of traffic-light phase order and length
//
// Purpose: samples the active-low LED code, locks onto red -> green -> blue,
// checks each phase length, pulses errors and counts correct cycles.
// Optional feature macro: MON_STICKY_ERR_EN adds sticky err_status.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   mon  traffic_phase_monitor_if.slave (led_in in; phase, phase_valid,
//        err_code, err_order, err_len, cycle_done, cycle_count out)
module traffic_phase_monitor
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES   = 10,
  parameter int GREEN_CYCLES = 5,
  parameter int BLUE_CYCLES  = 3,
  parameter int CNT_W        = 5
) (
  input logic                    clk,
  input logic                    rst,
  traffic_phase_monitor_if.slave mon
);

  function automatic logic [CNT_W-1:0] expected_len(phase_e p);
    case (p)
      PH_RED:   return CNT_W'(RED_CYCLES);
      PH_GREEN: return CNT_W'(GREEN_CYCLES);
      PH_BLUE:  return CNT_W'(BLUE_CYCLES);
      default:  return '0;
    endcase
  endfunction

  logic [2:0]       led_q;
  logic [CNT_W-1:0] run_len;
  logic             change;
  phase_e           code_ph;

  // PH_NONE is the SYNC (unlocked) state.
  phase_e     state_q, state_d;
  logic       overrun_q, overrun_d;
  logic       cycle_ok_q, cycle_ok_d;
  logic [7:0] count_q, count_d;
  logic       phase_valid_q;
  logic       err_code_q, err_code_d;
  logic       err_order_q, err_order_d;
  logic       err_len_q, err_len_d;
  logic       cycle_done_q, cycle_done_d;

  assign change  = (mon.led_in != led_q);
  assign code_ph = led_to_phase(mon.led_in);

  traffic_run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .clk       (clk),
    .rst       (rst),
    .restart_i (change),
    .run_len_o (run_len)
  );

  always_comb begin
    state_d      = state_q;
    overrun_d    = overrun_q;
    cycle_ok_d   = cycle_ok_q;
    count_d      = count_q;
    err_code_d   = 1'b0;
    err_order_d  = 1'b0;
    err_len_d    = 1'b0;
    cycle_done_d = 1'b0;

    if (change) begin
      overrun_d = 1'b0;
      if (state_q == PH_NONE) begin
        if (code_ph == PH_RED) begin
          state_d    = PH_RED;
          cycle_ok_d = 1'b1;
        end else if (led_is_illegal(mon.led_in)) begin
          err_code_d = 1'b1;
        end
      end else if (code_ph == PH_NONE) begin
        // Illegal code or all-off while locked.
        err_code_d = 1'b1;
        state_d    = PH_NONE;
      end else if (code_ph == phase_succ(state_q)) begin
        state_d = code_ph;
        // A phase already flagged as overrun is not reported a second time.
        if (run_len != expected_len(state_q) && !overrun_q) begin
          err_len_d  = 1'b1;
          cycle_ok_d = 1'b0;
        end
        if (code_ph == PH_RED) begin
          // The blue length check above takes part in judging this cycle.
          cycle_done_d = cycle_ok_d;
          cycle_ok_d   = 1'b1;
          if (cycle_done_d && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
        end
      end else begin
        err_order_d = 1'b1;
        if (code_ph == PH_RED) begin
          state_d    = PH_RED;
          cycle_ok_d = 1'b1;
        end else begin
          state_d = PH_NONE;
        end
      end
    end else if (state_q != PH_NONE && !overrun_q &&
                 run_len == expected_len(state_q)) begin
      // This edge takes run length to expected+1: phase is stuck.
      err_len_d  = 1'b1;
      overrun_d  = 1'b1;
      cycle_ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q         <= LED_OFF;
      state_q       <= PH_NONE;
      overrun_q     <= 1'b0;
      cycle_ok_q    <= 1'b1;
      count_q       <= 8'd0;
      phase_valid_q <= 1'b0;
      err_code_q    <= 1'b0;
      err_order_q   <= 1'b0;
      err_len_q     <= 1'b0;
      cycle_done_q  <= 1'b0;
    end else begin
      led_q         <= mon.led_in;
      state_q       <= state_d;
      overrun_q     <= overrun_d;
      cycle_ok_q    <= cycle_ok_d;
      count_q       <= count_d;
      phase_valid_q <= (state_d != PH_NONE);
      err_code_q    <= err_code_d;
      err_order_q   <= err_order_d;
      err_len_q     <= err_len_d;
      cycle_done_q  <= cycle_done_d;
    end
  end

  assign mon.phase       = state_q;
  assign mon.phase_valid = phase_valid_q;
  assign mon.err_code    = err_code_q;
  assign mon.err_order   = err_order_q;
  assign mon.err_len     = err_len_q;
  assign mon.cycle_done  = cycle_done_q;
  assign mon.cycle_count = count_q;

`ifdef MON_STICKY_ERR_EN
  logic [2:0] err_status_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_status_q <= 3'b000;
    end else begin
      err_status_q <= err_status_q | {err_len_d, err_order_d, err_code_d};
    end
  end

  assign mon.err_status = err_status_q;
`endif

endmodule
